// File: rtl/rpsc_ilk_pkg.sv
// -----------------------------------------------------------------------------
// rpsc_ilk_pkg
// Shared types and helpers for the RPSC interlock input bank.
//   RPSC_TS_W      : width of the optional first-fault timestamp
//   RPSC_MAX_CH    : widest channel vector the priority encoder accepts
//   ts_t           : timestamp / free-running cycle counter type
//   lowest_set_idx : priority encoder, lowest set bit wins
// -----------------------------------------------------------------------------
package rpsc_ilk_pkg;

   localparam int RPSC_TS_W   = 32;
   localparam int RPSC_MAX_CH = 64;

   typedef logic [RPSC_TS_W-1:0] ts_t;

   // Returns the index of the lowest set bit, 0 when the vector is empty.
   // Scanning from the top down lets the lowest hit overwrite higher ones.
   function automatic int unsigned lowest_set_idx(input logic [RPSC_MAX_CH-1:0] v);
      lowest_set_idx = 0;
      for (int i = RPSC_MAX_CH - 1; i >= 0; i--) begin
         if (v[i]) lowest_set_idx = $unsigned(i);
      end
   endfunction

endpackage : rpsc_ilk_pkg

// File: rtl/channel_debounce.sv
// -----------------------------------------------------------------------------
// channel_debounce
// Synchroniser plus debounce filter for a single interlock input.
// Ports:
//   clk      : divided system clock
//   reset    : synchronous, active-low reset
//   raw      : asynchronous raw input
//   filtered : debounced level; changes only after DEBOUNCE_CYCLES
//              consecutive synchronised samples disagree with it
// Parameters: SYNC_STAGES (>=2), DEBOUNCE_CYCLES (>=1), RESET_VAL (the
// non-fault level loaded into every flop on reset).
// -----------------------------------------------------------------------------
module channel_debounce #(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 16,
   parameter logic RESET_VAL       = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic filtered
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_out;
   logic [CNT_W-1:0]       cnt;

   always_ff @(posedge clk) begin
      if (!reset) sync_q <= {SYNC_STAGES{RESET_VAL}};
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

   // Any agreement restarts the count, so only an uninterrupted run of
   // DEBOUNCE_CYCLES differing samples moves the output. The count clears
   // on the accepting edge and therefore never wraps.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt      <= '0;
         filtered <= RESET_VAL;
      end else if (sync_out == filtered) begin
         cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
         filtered <= sync_out;
         cnt      <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule : channel_debounce

// File: rtl/interlock_input_bank.sv
// -----------------------------------------------------------------------------
// interlock_input_bank
// Conditions NUM_CH raw interlock inputs: synchroniser, debounce, per-channel
// fault latch, first-fault capture and lamp-test overlay.
// Optional feature macro: RPSC_FAULT_TIMESTAMP_EN (adds a free-running cycle
// counter and o_first_ts).
// Ports:
//   clk, reset     : clock, synchronous active-low reset
//   i_raw          : asynchronous raw inputs
//   i_clear        : fault clear, acted on at its rising edge
//   i_lamp_test    : forces every lamp on
//   o_filtered     : debounced input levels
//   o_fault        : live fault per channel
//   o_latched      : held fault flags
//   o_lamp         : o_latched with the lamp-test overlay
//   o_any_fault    : OR of o_latched
//   o_new_fault    : one-cycle pulse when any latched bit rises
//   o_first_valid  : first-fault record present; o_first_idx (and o_first_ts)
//                    are meaningful only while it is high. It drops for one
//                    cycle on a clear, then re-captures if faults survive.
//   o_first_idx    : lowest index among the first latched faults
//   o_first_ts     : (macro only) cycle counter value at capture
// -----------------------------------------------------------------------------
module interlock_input_bank
   import rpsc_ilk_pkg::*;
#(
   parameter int                NUM_CH          = 43,
   parameter int                SYNC_STAGES     = 2,
   parameter int                DEBOUNCE_CYCLES = 16,
   parameter logic [NUM_CH-1:0] ACTIVE_LEVEL    = {NUM_CH{1'b1}}
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_CH-1:0]         i_raw,
   input  logic                      i_clear,
   input  logic                      i_lamp_test,
   output logic [NUM_CH-1:0]         o_filtered,
   output logic [NUM_CH-1:0]         o_fault,
   output logic [NUM_CH-1:0]         o_latched,
   output logic [NUM_CH-1:0]         o_lamp,
   output logic                      o_any_fault,
   output logic                      o_new_fault,
   output logic                      o_first_valid,
   output logic [$clog2(NUM_CH)-1:0] o_first_idx
`ifdef RPSC_FAULT_TIMESTAMP_EN
   ,
   output ts_t                       o_first_ts
`endif
);

   localparam int IDX_W = $clog2(NUM_CH);

   logic              clear_q;
   logic              clear_rise;
   logic [NUM_CH-1:0] latched_next;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      channel_debounce #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_VAL       (~ACTIVE_LEVEL[g])
      ) u_deb (
         .clk      (clk),
         .reset    (reset),
         .raw      (i_raw[g]),
         .filtered (o_filtered[g])
      );
   end

   assign o_fault     = ~(o_filtered ^ ACTIVE_LEVEL);
   assign o_lamp      = o_latched | {NUM_CH{i_lamp_test}};
   assign o_any_fault = |o_latched;

   // A clear reloads the latch from the live faults, so a channel that is
   // faulted in the clearing cycle stays set and is not reported as new.
   always_comb begin
      clear_rise   = i_clear & ~clear_q;
      latched_next = o_latched | o_fault;
      if (clear_rise) latched_next = o_fault;
   end

`ifdef RPSC_FAULT_TIMESTAMP_EN
   ts_t cycle_cnt;

   always_ff @(posedge clk) begin
      if (!reset) cycle_cnt <= '0;
      else        cycle_cnt <= cycle_cnt + ts_t'(1);
   end
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         clear_q       <= 1'b0;
         o_latched     <= '0;
         o_new_fault   <= 1'b0;
         o_first_valid <= 1'b0;
         o_first_idx   <= '0;
`ifdef RPSC_FAULT_TIMESTAMP_EN
         o_first_ts    <= '0;
`endif
      end else begin
         clear_q     <= i_clear;
         o_latched   <= latched_next;
         o_new_fault <= |(latched_next & ~o_latched);
         if (clear_rise) begin
            o_first_valid <= 1'b0;
         end else if (!o_first_valid && (|latched_next)) begin
            o_first_valid <= 1'b1;
            o_first_idx   <= IDX_W'(lowest_set_idx(RPSC_MAX_CH'(latched_next)));
`ifdef RPSC_FAULT_TIMESTAMP_EN
            o_first_ts    <= cycle_cnt;
`endif
         end
      end
   end

endmodule : interlock_input_bank

// File: tb/tb_interlock_input_bank.sv
// -----------------------------------------------------------------------------
// tb_interlock_input_bank
// Directed bench for interlock_input_bank with NUM_CH=4, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, ACTIVE_LEVEL=4'b1111. Each expected new-fault event
// {o_latched, o_first_valid, o_first_idx} is queued when stimulus is issued;
// a monitor pops and compares whenever o_new_fault pulses.
// -----------------------------------------------------------------------------
module tb_interlock_input_bank;
   import rpsc_ilk_pkg::*;

   localparam int NUM_CH = 4;
   localparam int IDX_W  = 2;
   localparam int W      = NUM_CH + 1 + IDX_W;

   logic              clk;
   logic              reset;
   logic [NUM_CH-1:0] i_raw;
   logic              i_clear;
   logic              i_lamp_test;
   logic [NUM_CH-1:0] o_filtered;
   logic [NUM_CH-1:0] o_fault;
   logic [NUM_CH-1:0] o_latched;
   logic [NUM_CH-1:0] o_lamp;
   logic              o_any_fault;
   logic              o_new_fault;
   logic              o_first_valid;
   logic [IDX_W-1:0]  o_first_idx;
`ifdef RPSC_FAULT_TIMESTAMP_EN
   ts_t               o_first_ts;
`endif

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

   interlock_input_bank #(
      .NUM_CH          (NUM_CH),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4),
      .ACTIVE_LEVEL    (4'b1111)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .i_raw         (i_raw),
      .i_clear       (i_clear),
      .i_lamp_test   (i_lamp_test),
      .o_filtered    (o_filtered),
      .o_fault       (o_fault),
      .o_latched     (o_latched),
      .o_lamp        (o_lamp),
      .o_any_fault   (o_any_fault),
      .o_new_fault   (o_new_fault),
      .o_first_valid (o_first_valid),
      .o_first_idx   (o_first_idx)
`ifdef RPSC_FAULT_TIMESTAMP_EN
      ,
      .o_first_ts    (o_first_ts)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver tasks: inputs change and are checked on the falling edge
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_event(input logic [NUM_CH-1:0] latched, input logic [IDX_W-1:0] idx);
      exp_q.push_back({latched, 1'b1, idx});
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (reset === 1'b1 && o_new_fault === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL new_fault_unexpected: got latched=%b first_valid=%b idx=%0d, no event queued",
                     o_latched, o_first_valid, o_first_idx);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if ({o_latched, o_first_valid, o_first_idx} !== e) begin
               errors++;
               $display("FAIL new_fault_event: got %b expected %b",
                        {o_latched, o_first_valid, o_first_idx}, e);
            end
         end
      end
   end

   initial begin
      reset       = 1'b0;
      i_raw       = '0;
      i_clear     = 1'b0;
      i_lamp_test = 1'b0;

      // reset state
      step(3);
      check("rst_filtered", 32'(o_filtered), 32'h0);
      check("rst_latched", 32'(o_latched), 32'h0);
      check("rst_first_valid", 32'(o_first_valid), 32'h0);
      check("rst_new_fault", 32'(o_new_fault), 32'h0);
      check("rst_lamp", 32'(o_lamp), 32'h0);
      reset = 1'b1;
      step($urandom_range(2, 5));

      // glitch of 3 cycles is rejected
      i_raw = 4'b0010;
      step(3);
      i_raw = 4'b0000;
      step(10);
      check("glitch_filtered", 32'(o_filtered), 32'h0);
      check("glitch_latched", 32'(o_latched), 32'h0);

      // valid fault on channel 1: filtered at edge 6, latched at edge 7
      expect_event(4'b0010, 2'd1);
      i_raw = 4'b0010;
      step(5);
      check("fault_filtered_early", 32'(o_filtered), 32'h0);
      step(1);
      check("fault_filtered_c6", 32'(o_filtered), 32'h2);
      check("fault_live", 32'(o_fault), 32'h2);
      check("fault_latched_c6", 32'(o_latched), 32'h0);
      step(1);
      check("fault_latched_c7", 32'(o_latched), 32'h2);
      check("fault_new_pulse", 32'(o_new_fault), 32'h1);
      step(1);
      check("fault_new_single", 32'(o_new_fault), 32'h0);
      check("fault_first_valid", 32'(o_first_valid), 32'h1);
      check("fault_first_idx", 32'(o_first_idx), 32'h1);
      check("fault_any", 32'(o_any_fault), 32'h1);

      // release and fully clear
      i_raw = 4'b0000;
      step(8);
      check("release_latched_held", 32'(o_latched), 32'h2);
      i_clear = 1'b1;
      step(1);
      check("clear_all_latched", 32'(o_latched), 32'h0);
      check("clear_all_first_valid", 32'(o_first_valid), 32'h0);
      i_clear = 1'b0;
      step(2);
      check("clear_all_stays_empty", 32'(o_first_valid), 32'h0);

      // simultaneous faults on channels 2 and 0
      expect_event(4'b0101, 2'd0);
      i_raw = 4'b0101;
      step(7);
      check("simul_latched", 32'(o_latched), 32'h5);
      step(1);
      check("simul_first_idx", 32'(o_first_idx), 32'h0);

      // partial clear: ch0 still faulted, ch2 released
      i_raw = 4'b0001;
      step(8);
      check("partial_pre_latched", 32'(o_latched), 32'h5);
      check("partial_pre_filtered", 32'(o_filtered), 32'h1);
      i_clear = 1'b1;
      step(1);
      check("partial_latched", 32'(o_latched), 32'h1);
      check("partial_no_new", 32'(o_new_fault), 32'h0);
      check("partial_first_drop", 32'(o_first_valid), 32'h0);
      step(1);
      check("partial_first_recap", 32'(o_first_valid), 32'h1);
      check("partial_first_idx", 32'(o_first_idx), 32'h0);
      step(2);
      check("partial_level_clear_held", 32'(o_latched), 32'h1);
      i_clear = 1'b0;

      // lamp test overlay
      step(1);
      i_lamp_test = 1'b1;
      #1;
      check("lamp_on", 32'(o_lamp), 32'hf);
      check("lamp_on_latched", 32'(o_latched), 32'h1);
      step(3);
      i_lamp_test = 1'b0;
      #1;
      check("lamp_off", 32'(o_lamp), 32'h1);
      check("lamp_off_latched", 32'(o_latched), 32'h1);

      // reset mid-debounce discards the partial count
      step(1);
      i_raw = 4'b1000;
      step(3);
      reset = 1'b0;
      step(1);
      check("midrst_latched", 32'(o_latched), 32'h0);
      check("midrst_filtered", 32'(o_filtered), 32'h0);
      expect_event(4'b1000, 2'd3);
      reset = 1'b1;
      step(5);
      check("midrst_filtered_early", 32'(o_filtered), 32'h0);
      step(1);
      check("midrst_filtered_c6", 32'(o_filtered), 32'h8);
      step(2);
      check("midrst_first_idx", 32'(o_first_idx), 32'h3);

`ifdef RPSC_FAULT_TIMESTAMP_EN
      // counter reads 100 on the 101st edge after reset release
      i_raw = 4'b0000;
      reset = 1'b0;
      step(2);
      reset = 1'b1;
      step(94);
      expect_event(4'b0100, 2'd2);
      i_raw = 4'b0100;
      step(7);
      check("ts_capture", o_first_ts, 32'd100);
      expect_event(4'b0101, 2'd2);
      i_raw = 4'b0101;
      step(8);
      check("ts_held", o_first_ts, 32'd100);
      check("ts_idx_held", 32'(o_first_idx), 32'h2);
`endif

      step(4);
      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_interlock_input_bank

// File: doc/interlock_input_bank.md
Name: interlock_input_bank

Overview:
- Parametrised successor to the per-signal input flip-flop bank used at the RPSC top level.
- Conditions NUM_CH raw interlock inputs: synchroniser, debounce filter, per-channel fault latch, first-fault capture, lamp-test overlay.
- Sits between the FPGA input pins and the RPSC card logic. Its filtered outputs replace the *_FF signals; its latched/lamp outputs drive the LA_* indicators.

Parameters:
- NUM_CH, 43, number of input channels.
- SYNC_STAGES, 2, synchroniser flops per channel (min 2).
- DEBOUNCE_CYCLES, 16, consecutive stable cycles before the filtered value changes (min 1).
- ACTIVE_LEVEL, {NUM_CH{1'b1}}, per-bit fault polarity (1: fault when input high; 0: fault when input low).

Ports:
- clk  in  1  divided system clock.
- reset  in  1  synchronous, active-low reset.
- i_raw  in  NUM_CH  asynchronous raw inputs.
- i_clear  in  1  fault clear (reset_hold_error), level input, rising-edge detected.
- i_lamp_test  in  1  lamp test (LA_TEST).
- o_filtered  out  NUM_CH  debounced input level.
- o_fault  out  NUM_CH  live fault: o_filtered XNOR ACTIVE_LEVEL.
- o_latched  out  NUM_CH  held fault flags.
- o_lamp  out  NUM_CH  o_latched OR {NUM_CH{i_lamp_test}}.
- o_any_fault  out  1  OR of o_latched.
- o_new_fault  out  1  one-cycle pulse when any o_latched bit goes 0->1.
- o_first_valid  out  1  first-fault record valid.
- o_first_idx  out  $clog2(NUM_CH)  index of the first latched channel.

Behaviour:
- Reset (reset==0 at a clk edge):
  - Synchroniser flops load ~ACTIVE_LEVEL; o_filtered = ~ACTIVE_LEVEL (non-fault).
  - Debounce counters = 0; o_latched = 0; o_new_fault = 0; o_first_valid = 0; o_first_idx = 0; clear edge detector = 0.
- Reset mid-debounce discards the partial count.
- Synchroniser: SYNC_STAGES flop chain per channel; sync_out is the last stage.
- Debounce, per channel:
  - The counter increments while sync_out != filtered and clears to 0 when they are equal.
  - When the counter == DEBOUNCE_CYCLES-1 and the values still differ, filtered takes sync_out on that edge and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1); it never wraps.
  - Latency from a raw change to o_filtered = SYNC_STAGES + DEBOUNCE_CYCLES cycles.
  - A pulse shorter than DEBOUNCE_CYCLES synchronised cycles is rejected.
- Fault latch (registered, 1 cycle after o_fault):
  - Each cycle: latched <= latched | o_fault.
  - On an i_clear rising edge: latched <= o_fault. Channels that are still faulted stay set.
  - If clear and a new fault occur in the same cycle, the fault wins (bit stays 1).
- o_new_fault:
  - Registered; equals |(latched_next & ~latched).
  - Not asserted for bits that survive a clear.
- First-fault capture:
  - When o_first_valid==0 and latched_next != 0: o_first_valid <= 1, o_first_idx <= lowest set index of latched_next.
  - Simultaneous faults resolve to the lowest index.
  - The record holds until an i_clear rising edge, which drops o_first_valid for that cycle only.
  - If faults persist after the clear, the record is re-captured from the surviving set on the next cycle.
- o_lamp, o_fault and o_any_fault are combinational from registers.
- Lamp test never alters o_latched.

Optional Feature:
- Macro: RPSC_FAULT_TIMESTAMP_EN.
- With the macro defined:
  - Adds a free-running 32-bit cycle counter, reset to 0, that wraps modulo 2^32.
  - Adds output o_first_ts [31:0], loaded with the counter value in the same cycle o_first_valid sets, and held until the next capture.
  - o_first_ts resets to 0.
- Without the macro: neither the counter nor o_first_ts exists; the rest of the block is unchanged.

Decomposition:
- Package rpsc_ilk_pkg:
  - RPSC_TS_W = 32.
  - typedef ts_t.
  - function lowest_set_idx for the priority encoder.
- Sub-module channel_debounce: synchroniser plus debounce for one channel. Parameters: SYNC_STAGES, DEBOUNCE_CYCLES, RESET_VAL. Instantiated NUM_CH times in a generate loop.

Test Plan:
- Common setup: NUM_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, ACTIVE_LEVEL=4'b1111.
- Reset: reset=0 for 3 cycles with i_raw=4'b0000 -> o_filtered=0, o_latched=0, o_first_valid=0, o_new_fault=0, o_lamp=0.
- Glitch reject: i_raw[1]=1 for 3 cycles, then 0 -> o_filtered stays 0000, o_latched stays 0000.
- Valid fault: i_raw[1]=1 held from cycle 0 ->
  - o_filtered[1]=1 at cycle 6;
  - o_latched=4'b0010 and a single o_new_fault pulse at cycle 7;
  - o_first_idx=1, o_first_valid=1.
- Simultaneous: i_raw[2] and i_raw[0] rise in the same cycle -> o_latched=4'b0101, o_first_idx=0, one o_new_fault pulse.
- Partial clear: ch0 still high, ch2 released, then i_clear 0->1 ->
  - o_latched=4'b0001, no o_new_fault;
  - o_first_valid low for 1 cycle, then re-captured with o_first_idx=0.
- Lamp test: i_lamp_test=1 with o_latched=4'b0001 -> o_lamp=4'b1111. Dropping i_lamp_test -> o_lamp=4'b0001. o_latched never changes.
- Timestamp (RPSC_FAULT_TIMESTAMP_EN defined): the fault latches when the counter reads 100 -> o_first_ts=100, held through later faults.
